// File: rtl/key_event_unit.sv
// Multi-channel push-button conditioner: synchroniser, debounce, edge qualification,
// pulse stretching, long-press strobe and write-1-to-clear sticky event flags.
module key_event_unit #(
    parameter int unsigned WIDTH         = 2,
    parameter string       POLARITY      = "LOW",
    parameter int unsigned TIMEOUT       = 50000,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned PULSE_EXT     = 1,
    parameter int unsigned LONG_CYCLES   = 50000000,
    parameter int unsigned LONG_WIDTH    = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [2*WIDTH-1:0] edge_mode,
    input  logic [WIDTH-1:0]   event_clr,
    output logic [WIDTH-1:0]   level_out,
    output logic [WIDTH-1:0]   pulse_out,
    output logic [WIDTH-1:0]   long_out,
    output logic [WIDTH-1:0]   event_pending,
    output logic               irq
);

    // Idle pin level; also the synchroniser reset value so reset release is edge-free.
    localparam logic ActiveLow  = (POLARITY == "LOW");
    localparam int unsigned PulseWidth = $clog2(PULSE_EXT + 1);

    logic [WIDTH-1:0] pend_vec;
    logic             irq_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic                     sync1_q, sync2_q;
        logic                     pressed;
        logic                     level_q, level_d;
        logic                     level_prev_q;
        logic [TIMEOUT_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
        logic [1:0]               mode;
        logic                     rise, fall, edge_acc;
        logic [PulseWidth-1:0]    pulse_cnt_q, pulse_cnt_d;
        logic [LONG_WIDTH-1:0]    long_cnt_q, long_cnt_d;
        logic                     long_q, long_d;
        logic                     pend_q, pend_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= ActiveLow;
                sync2_q <= ActiveLow;
            end else begin
                sync1_q <= data_in[i];
                sync2_q <= sync1_q;
            end
        end

        assign pressed = sync2_q ^ ActiveLow;

        // Accept a new level only after TIMEOUT consecutive differing samples.
        always_comb begin
            level_d   = level_q;
            deb_cnt_d = '0;
            if (pressed != level_q) begin
                if (deb_cnt_q == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
                    level_d = ~level_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
        end

        assign mode     = edge_mode[2*i +: 2];
        assign rise     = level_q & ~level_prev_q;
        assign fall     = ~level_q & level_prev_q;
        assign edge_acc = (rise & mode[0]) | (fall & mode[1]);

        always_comb begin
            pulse_cnt_d = pulse_cnt_q;
            if (edge_acc) begin
                pulse_cnt_d = PulseWidth'(PULSE_EXT);
            end else if (pulse_cnt_q != '0) begin
                pulse_cnt_d = pulse_cnt_q - 1'b1;
            end
        end

        // Counter saturates at LONG_CYCLES so each press yields a single strobe.
        always_comb begin
            long_cnt_d = long_cnt_q;
            if (!level_q) begin
                long_cnt_d = '0;
            end else if (long_cnt_q != LONG_WIDTH'(LONG_CYCLES)) begin
                long_cnt_d = long_cnt_q + 1'b1;
            end
        end

        assign long_d = level_q && (long_cnt_q == LONG_WIDTH'(LONG_CYCLES - 1));

        // Set has priority over a simultaneous clear.
        assign pend_d = (pend_q & ~event_clr[i]) | edge_acc | long_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                deb_cnt_q    <= '0;
                pulse_cnt_q  <= '0;
                long_cnt_q   <= '0;
                long_q       <= 1'b0;
                pend_q       <= 1'b0;
            end else begin
                level_q      <= level_d;
                level_prev_q <= level_q;
                deb_cnt_q    <= deb_cnt_d;
                pulse_cnt_q  <= pulse_cnt_d;
                long_cnt_q   <= long_cnt_d;
                long_q       <= long_d;
                pend_q       <= pend_d;
            end
        end

        assign level_out[i]     = level_q;
        assign pulse_out[i]     = (pulse_cnt_q != '0);
        assign long_out[i]      = long_q;
        assign event_pending[i] = pend_q;
        assign pend_vec[i]      = pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |pend_vec;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_key_event_unit.sv
// Randomised bench for key_event_unit, checked every cycle against a window-based
// behavioural model plus directed latency, glitch, long-press, W1C and reset checks.
module tb_key_event_unit;

    localparam int W = 2;
    localparam int T = 4;
    localparam int P = 3;
    localparam int L = 20;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   data_in;
    logic [2*W-1:0] edge_mode;
    logic [W-1:0]   event_clr;
    logic [W-1:0]   level_out, pulse_out, long_out, event_pending;
    logic           irq;

    key_event_unit #(
        .WIDTH        (W),
        .POLARITY     ("LOW"),
        .TIMEOUT      (T),
        .TIMEOUT_WIDTH(4),
        .PULSE_EXT    (P),
        .LONG_CYCLES  (L),
        .LONG_WIDTH   (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .edge_mode    (edge_mode),
        .event_clr    (event_clr),
        .level_out    (level_out),
        .pulse_out    (pulse_out),
        .long_out     (long_out),
        .event_pending(event_pending),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: pressed samples after a two-stage delay; level flips when the
    // last T samples all disagree with it; events derived from cycle timestamps.
    bit sync1_m [W];
    bit sync2_m [W];
    bit hist    [W][T];
    int hist_n  [W];
    bit m_level [W];
    bit m_prev  [W];
    int rise_at [W];
    bit pulse_v [W];
    int pulse_at[W];
    bit m_long  [W];
    bit m_pend  [W];
    bit m_irq;

    task automatic model_reset();
        for (int c = 0; c < W; c++) begin
            sync1_m[c] = 0; sync2_m[c] = 0; hist_n[c] = 0;
            m_level[c] = 0; m_prev[c] = 0; rise_at[c] = 0;
            pulse_v[c] = 0; pulse_at[c] = 0; m_long[c] = 0; m_pend[c] = 0;
        end
        m_irq = 0;
    endtask

    task automatic model_step(input logic [W-1:0] pin, input logic [2*W-1:0] mode,
                              input logic [W-1:0] clr);
        bit any_pend;
        any_pend = 0;
        for (int c = 0; c < W; c++) any_pend |= m_pend[c];
        for (int c = 0; c < W; c++) begin
            bit acc, lng, all_diff, nxt;
            for (int k = T - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = sync2_m[c];
            if (hist_n[c] < T) hist_n[c]++;
            all_diff = (hist_n[c] == T);
            for (int k = 0; k < T; k++) if (hist[c][k] == m_level[c]) all_diff = 0;
            acc = (m_level[c] && !m_prev[c] && mode[2*c]) ||
                  (!m_level[c] && m_prev[c] && mode[2*c+1]);
            lng = m_level[c] && (cyc - rise_at[c] == L - 1);
            nxt = all_diff ? !m_level[c] : m_level[c];
            if (acc) begin
                pulse_v[c]  = 1;
                pulse_at[c] = cyc + 1;
            end
            m_pend[c] = (m_pend[c] && !clr[c]) || acc || lng;
            m_long[c] = lng;
            m_prev[c] = m_level[c];
            if (nxt && !m_level[c]) rise_at[c] = cyc + 1;
            m_level[c] = nxt;
            sync2_m[c] = sync1_m[c];
            sync1_m[c] = !pin[c];
        end
        m_irq = any_pend;
        cyc++;
    endtask

    task automatic compare();
        logic [W-1:0] el, ep, elg, epd;
        for (int c = 0; c < W; c++) begin
            el[c]  = m_level[c];
            ep[c]  = pulse_v[c] && (cyc >= pulse_at[c]) && (cyc - pulse_at[c] < P);
            elg[c] = m_long[c];
            epd[c] = m_pend[c];
        end
        check("level_out", level_out, el);
        check("pulse_out", pulse_out, ep);
        check("long_out", long_out, elg);
        check("event_pending", event_pending, epd);
        check("irq", irq, m_irq);
    endtask

    logic [2*W-1:0] cur_mode;

    task automatic cycle(input logic [W-1:0] pin, input logic [W-1:0] clr);
        @(negedge clk);
        compare();
        data_in   = pin;
        edge_mode = cur_mode;
        event_clr = clr;
        model_step(pin, cur_mode, clr);
    endtask

    task automatic run(input logic [W-1:0] pin, input int n);
        for (int k = 0; k < n; k++) cycle(pin, '0);
    endtask

    task automatic reset_mid(input logic [W-1:0] pin);
        @(negedge clk);
        compare();
        #2 rst_n = 1'b0;
        #1;
        check("rst_level", level_out, 0);
        check("rst_pulse", pulse_out, 0);
        check("rst_long", long_out, 0);
        check("rst_pending", event_pending, 0);
        check("rst_irq", irq, 0);
        model_reset();
        data_in   = pin;
        event_clr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(pin, edge_mode, event_clr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        int lat, irq_lat, pulse_hi, seen, rise_k, strobe_k, strobes;
        logic [W-1:0] pin;
        int hold [W];

        rst_n     = 1'b0;
        data_in   = '1;
        cur_mode  = 4'b0101;
        edge_mode = cur_mode;
        event_clr = '0;
        model_reset();
        #1;
        check("init_level", level_out, 0);
        check("init_pending", event_pending, 0);
        check("init_irq", irq, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(data_in, edge_mode, event_clr);
        run(2'b11, 6);

        // Press channel 0: latency, pulse width, irq delay.
        lat = -1; irq_lat = -1; pulse_hi = 0;
        for (int k = 1; k <= 14; k++) begin
            cycle(2'b10, '0);
            if (lat < 0 && level_out[0]) lat = k - 1;
            if (irq_lat < 0 && irq) irq_lat = k - 1;
            if (pulse_out[0]) pulse_hi++;
        end
        check("press_latency", lat, 2 + T);
        check("pulse_width", pulse_hi, P);
        check("irq_latency", irq_lat, 2 + T + 2);
        check("pending0_set", event_pending[0], 1);
        run(2'b11, 12);

        // Short glitches on channel 1 must be ignored.
        seen = 0;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 6; k++) begin
                cycle((k < 3) ? 2'b01 : 2'b11, '0);
                seen |= int'(level_out[1] | pulse_out[1] | event_pending[1]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            cycle(2'b11, '0);
            seen |= int'(level_out[1] | pulse_out[1] | event_pending[1]);
        end
        check("glitch_quiet", seen, 0);

        // Long press on channel 1, then release and re-press.
        rise_k = -1; strobe_k = -1; strobes = 0;
        for (int k = 1; k <= 50; k++) begin
            cycle(2'b01, '0);
            if (rise_k < 0 && level_out[1]) rise_k = k;
            if (long_out[1]) begin
                strobes++;
                if (strobe_k < 0) strobe_k = k;
            end
        end
        check("long_delay", strobe_k - rise_k, L);
        check("long_count", strobes, 1);
        run(2'b11, 10);
        strobes = 0;
        for (int k = 1; k <= 32; k++) begin
            cycle(2'b01, '0);
            if (long_out[1]) strobes++;
        end
        check("long_rearm", strobes, 1);
        run(2'b11, 15);

        // W1C clear with no event, then clear colliding with a new edge.
        cycle(2'b11, 2'b11);
        cycle(2'b11, '0);
        check("clr_pending", event_pending, 0);
        check("clr_irq_hold", irq, 1);
        cycle(2'b11, '0);
        check("clr_irq_drop", irq, 0);
        cur_mode = 4'b1111;
        for (int k = 1; k <= 10; k++) cycle(2'b10, (k == 7) ? 2'b01 : 2'b00);
        check("set_wins", event_pending[0], 1);
        run(2'b11, 12);

        // Reset mid-debounce with the pin held pressed across reset.
        cur_mode = 4'b0101;
        run(2'b10, 3);
        reset_mid(2'b10);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle(2'b10, '0);
            if (lat < 0 && level_out[0]) lat = k;
        end
        check("reset_press_latency", lat, 2 + T);
        run(2'b11, 8);
        reset_mid(2'b11);
        run(2'b11, 10);

        // Randomised phase.
        pin = 2'b11;
        for (int c = 0; c < W; c++) hold[c] = 1;
        for (int n = 0; n < 2500; n++) begin
            logic [W-1:0] clr;
            for (int c = 0; c < W; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    pin[c] = ~pin[c];
                    case ($urandom_range(0, 2))
                        0:       hold[c] = $urandom_range(1, 3);
                        1:       hold[c] = $urandom_range(4, 9);
                        default: hold[c] = $urandom_range(18, 40);
                    endcase
                end
                clr[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 63) == 0) cur_mode = 4'($urandom);
            if ($urandom_range(0, 799) == 0) reset_mid(pin);
            else cycle(pin, clr);
        end
        @(negedge clk);
        compare();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
